// File: rtl/prog_mem_port_arbiter.sv
// ============================================================================
//  Module   : prog_mem_port_arbiter
//  Purpose  : Shares one single-port synchronous program memory between the
//             instruction-fetch requester and the data load/store requester.
//             Data wins by default. A saturating starvation counter hands the
//             port to fetch after STARVE_MAX consecutive denied fetch cycles.
//             Read data returns exactly one cycle after the grant.
//  Ports    :
//    clk, reset                 clock (rising edge), async active-high reset
//    if_req/if_addr             fetch request and byte address
//    if_gnt                     fetch accepted this cycle (combinational)
//    if_rvalid/if_rdata/if_err  fetch response, one cycle after grant
//    d_req/d_we/d_addr/d_wdata/d_be  data request (load or store)
//    d_gnt                      data accepted this cycle (combinational)
//    d_rvalid/d_rdata           data response or store ack, one cycle later
//    mem_en/mem_we/mem_be/mem_idx/mem_wdata  memory drive, same cycle as grant
//    mem_rdata                  memory read data, one cycle after a read
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module prog_mem_port_arbiter #(
  parameter int MEM_WORDS  = 1024,
  parameter int IDX_W      = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [31:0]      if_rdata,
  output logic             if_err,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [31:0]      d_addr,
  input  logic [31:0]      d_wdata,
  input  logic [3:0]       d_be,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [31:0]      d_rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [IDX_W-1:0] mem_idx,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  localparam logic [3:0]       STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [IDX_W-1:0] IDX_MASK   = IDX_W'(MEM_WORDS - 1);

  // Identifies which requester (and what kind of access) owns the response
  // slot in the cycle after a grant.
  typedef enum logic [2:0] {
    TAG_NONE      = 3'd0,
    TAG_FETCH     = 3'd1,
    TAG_FETCH_ERR = 3'd2,
    TAG_LOAD      = 3'd3,
    TAG_STORE     = 3'd4
  } resp_tag_t;

  resp_tag_t  resp_tag, resp_tag_nxt;
  logic [3:0] starve_cnt, starve_cnt_nxt;
  logic       force_fetch;
  logic       if_misaligned;

  // Address bits outside the word index are intentionally ignored, so
  // accesses wrap modulo MEM_WORDS.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{d_addr[31:IDX_W+2], d_addr[1:0], if_addr[31:IDX_W+2]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_tag   <= TAG_NONE;
      starve_cnt <= 4'd0;
    end else begin
      resp_tag   <= resp_tag_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  always_comb begin
    force_fetch    = (starve_cnt == STARVE_LIM);
    if_misaligned  = (if_addr[1:0] != 2'b00);

    // Grants are held low while reset is asserted so every output is 0 in
    // the same cycle the reset arrives, not just after the next edge.
    d_gnt          = !reset && d_req && !(force_fetch && if_req);
    if_gnt         = !reset && if_req && !d_gnt;

    starve_cnt_nxt = 4'd0;
    if (if_req && !if_gnt) begin
      starve_cnt_nxt = force_fetch ? STARVE_LIM : starve_cnt + 4'd1;
    end

    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_be       = 4'h0;
    mem_idx      = '0;
    mem_wdata    = 32'h0;
    resp_tag_nxt = TAG_NONE;

    if (d_gnt) begin
      mem_en       = 1'b1;
      mem_we       = d_we;
      mem_be       = d_we ? d_be : 4'hF;
      mem_idx      = d_addr[IDX_W+1:2] & IDX_MASK;
      mem_wdata    = d_we ? d_wdata : 32'h0;
      resp_tag_nxt = d_we ? TAG_STORE : TAG_LOAD;
    end else if (if_gnt) begin
      // A misaligned fetch is accepted but never touches the memory; it is
      // answered with an error response instead.
      mem_en       = !if_misaligned;
      mem_be       = 4'hF;
      mem_idx      = if_addr[IDX_W+1:2] & IDX_MASK;
      resp_tag_nxt = if_misaligned ? TAG_FETCH_ERR : TAG_FETCH;
    end

    if_rvalid = (resp_tag == TAG_FETCH) || (resp_tag == TAG_FETCH_ERR);
    if_err    = (resp_tag == TAG_FETCH_ERR);
    if_rdata  = (resp_tag == TAG_FETCH) ? mem_rdata : 32'h0;
    d_rvalid  = (resp_tag == TAG_LOAD) || (resp_tag == TAG_STORE);
    d_rdata   = (resp_tag == TAG_LOAD) ? mem_rdata : 32'h0;
  end

endmodule

`default_nettype wire

// File: tb/tb_prog_mem_port_arbiter.sv
// ============================================================================
//  Module   : tb_prog_mem_port_arbiter
//  Purpose  : Directed self-checking bench for prog_mem_port_arbiter with a
//             behavioural single-port synchronous program memory attached.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prog_mem_port_arbiter;

  localparam int MEM_WORDS  = 1024;
  localparam int IDX_W      = 10;
  localparam int STARVE_MAX = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             if_req;
  logic [31:0]      if_addr;
  logic             if_gnt;
  logic             if_rvalid;
  logic [31:0]      if_rdata;
  logic             if_err;
  logic             d_req;
  logic             d_we;
  logic [31:0]      d_addr;
  logic [31:0]      d_wdata;
  logic [3:0]       d_be;
  logic             d_gnt;
  logic             d_rvalid;
  logic [31:0]      d_rdata;
  logic             mem_en;
  logic             mem_we;
  logic [3:0]       mem_be;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  logic [31:0] mem [MEM_WORDS];

  int checks = 0;
  int errors = 0;

  prog_mem_port_arbiter #(
    .MEM_WORDS (MEM_WORDS),
    .IDX_W     (IDX_W),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .if_err   (if_err),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_be     (d_be),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_be   (mem_be),
    .mem_idx  (mem_idx),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural program memory: each word preloaded with a recognisable
  // pattern so a returned word identifies the index it came from.
  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = init_word(i);
    mem_rdata = 32'h0;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_idx];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    if_req  = 1'b1;
    if_addr = 32'h400;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h10;
    d_wdata = 32'h1234_5678;
    d_be    = 4'hF;

    // Reset state, with both requesters pushing
    tick(); tick(); #1;
    chk("rst_if_gnt",    32'(if_gnt),    32'd0);
    chk("rst_d_gnt",     32'(d_gnt),     32'd0);
    chk("rst_mem_en",    32'(mem_en),    32'd0);
    chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst_d_rvalid",  32'(d_rvalid),  32'd0);
    chk("rst_if_rdata",  if_rdata,       32'h0);
    chk("rst_d_rdata",   d_rdata,        32'h0);
    @(negedge clk);
    reset  = 1'b0;
    if_req = 1'b0;
    d_req  = 1'b0;
    d_we   = 1'b0;

    // Fetch stream 0x400, 0x404, ...: grant every cycle, word one cycle later
    for (int k = 0; k < 4; k++) begin
      tick();
      if_req  = 1'b1;
      if_addr = 32'h400 + 32'(4 * k);
      #1;
      chk("fs_if_gnt",  32'(if_gnt),  32'd1);
      chk("fs_mem_en",  32'(mem_en),  32'd1);
      chk("fs_mem_we",  32'(mem_we),  32'd0);
      chk("fs_mem_be",  32'(mem_be),  32'hF);
      chk("fs_mem_idx", 32'(mem_idx), 32'h100 + 32'(k));
      if (k > 0) begin
        chk("fs_if_rvalid", 32'(if_rvalid), 32'd1);
        chk("fs_if_rdata",  if_rdata,       init_word(32'h100 + k - 1));
      end
    end
    tick();
    if_req = 1'b0;
    #1;
    chk("fs_last_rvalid", 32'(if_rvalid), 32'd1);
    chk("fs_last_rdata",  if_rdata,       init_word(32'h103));
    chk("fs_idle_gnt",    32'(if_gnt),    32'd0);

    // Contention: 4 data grants then 1 forced fetch grant, repeating
    for (int c = 0; c < 10; c++) begin
      tick();
      if_req  = 1'b1;
      if_addr = 32'h0;
      d_req   = 1'b1;
      d_we    = 1'b0;
      d_addr  = 32'h20;
      #1;
      chk("ct_d_gnt",  32'(d_gnt),  (c % 5 != 4) ? 32'd1 : 32'd0);
      chk("ct_if_gnt", 32'(if_gnt), (c % 5 == 4) ? 32'd1 : 32'd0);
      if (c > 0) begin
        chk("ct_d_rvalid",  32'(d_rvalid),  ((c - 1) % 5 != 4) ? 32'd1 : 32'd0);
        chk("ct_if_rvalid", 32'(if_rvalid), ((c - 1) % 5 == 4) ? 32'd1 : 32'd0);
        chk("ct_d_rdata",   d_rdata, ((c - 1) % 5 != 4) ? init_word(8) : 32'h0);
      end
    end
    tick();
    if_req = 1'b0;
    d_req  = 1'b0;
    #1;
    chk("ct_last_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("ct_last_if_rdata",  if_rdata,       init_word(0));

    // Store 0xDEADBEEF to 0x10, then load it back
    tick();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF;
    #1;
    chk("st_d_gnt",     32'(d_gnt),   32'd1);
    chk("st_mem_we",    32'(mem_we),  32'd1);
    chk("st_mem_idx",   32'(mem_idx), 32'h4);
    chk("st_mem_wdata", mem_wdata,    32'hDEAD_BEEF);
    tick();
    d_we = 1'b0; d_wdata = 32'h0;
    #1;
    chk("st_ack_rvalid", 32'(d_rvalid), 32'd1);
    chk("st_ack_rdata",  d_rdata,       32'h0);
    chk("ld_mem_we",     32'(mem_we),   32'd0);
    chk("ld_mem_be",     32'(mem_be),   32'hF);
    // Partial store into the same word right behind the load
    tick();
    d_we = 1'b1; d_wdata = 32'h1122_3344; d_be = 4'b0101;
    #1;
    chk("ld_rvalid",   32'(d_rvalid), 32'd1);
    chk("ld_rdata",    d_rdata,       32'hDEAD_BEEF);
    chk("pst_mem_be",  32'(mem_be),   32'h5);
    tick();
    d_we = 1'b0; d_wdata = 32'h0;
    #1;
    chk("pst_ack_rdata", d_rdata, 32'h0);
    tick();
    d_req = 1'b0;
    #1;
    chk("pld_rdata", d_rdata, 32'hDE22_BE44);

    // Misaligned fetch
    tick();
    if_req = 1'b1; if_addr = 32'h402;
    #1;
    chk("mis_if_gnt", 32'(if_gnt), 32'd1);
    chk("mis_mem_en", 32'(mem_en), 32'd0);
    tick();
    if_req = 1'b0;
    #1;
    chk("mis_rvalid", 32'(if_rvalid), 32'd1);
    chk("mis_err",    32'(if_err),    32'd1);
    chk("mis_rdata",  if_rdata,       32'h0);

    // Wrap: 0x1000 maps onto word 0
    tick();
    if_req = 1'b1; if_addr = 32'h1000;
    #1;
    chk("wrap_gnt", 32'(if_gnt),  32'd1);
    chk("wrap_idx", 32'(mem_idx), 32'h0);
    tick();
    if_req = 1'b0;
    #1;
    chk("wrap_rvalid", 32'(if_rvalid), 32'd1);
    chk("wrap_err",    32'(if_err),    32'd0);
    chk("wrap_rdata",  if_rdata,       init_word(0));

    // Reset arriving before the response edge drops the pending fetch
    tick();
    if_req = 1'b1; if_addr = 32'h404;
    #1;
    chk("rr_if_gnt", 32'(if_gnt), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rr_gnt_same_cycle",   32'(if_gnt), 32'd0);
    chk("rr_mem_en_same_cycle", 32'(mem_en), 32'd0);
    tick();
    if_req = 1'b0;
    chk("rr_rvalid_in_reset", 32'(if_rvalid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rr_no_replay_if", 32'(if_rvalid), 32'd0);
      chk("rr_no_replay_d",  32'(d_rvalid),  32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
